// File: rtl/datapath.sv
// Single-bus 32-bit RISC datapath: register file, special registers, 64-bit Z
// and a combinational ALU, all sequenced by externally supplied strobes.
module datapath (
    input  logic        clk,
    input  logic        clr,
    input  logic        R0out,
    input  logic        R1out,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R4out,
    input  logic        R5out,
    input  logic        R6out,
    input  logic        R7out,
    input  logic        R8out,
    input  logic        R9out,
    input  logic        R10out,
    input  logic        R11out,
    input  logic        R12out,
    input  logic        R13out,
    input  logic        R14out,
    input  logic        R15out,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        R0in,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        R8in,
    input  logic        R9in,
    input  logic        R10in,
    input  logic        R11in,
    input  logic        R12in,
    input  logic        R13in,
    input  logic        R14in,
    input  logic        R15in,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Yin,
    input  logic        Zin,
    input  logic        Read,
    input  logic [4:0]  OpCode,
    input  logic [31:0] Mdatain,
    output logic [31:0] BusMuxOut,
    output logic [31:0] IRout_val,
    output logic [31:0] MARout_val
);

    logic [15:0] rOutVec;
    logic [15:0] rInVec;

    logic [31:0] r_q [16];
    logic [31:0] r_d [16];
    logic [31:0] hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, ir_q, ir_d;
    logic [31:0] mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
    logic [63:0] z_q, z_d;

    logic [31:0]        busMux;
    logic [31:0]        opA, opB;
    logic [4:0]         shamt;
    logic [63:0]        aluRes;
    logic signed [63:0] product;
    logic signed [31:0] quot, rem;

    assign rOutVec = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign rInVec  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                      R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

    // Later assignments override earlier ones, so R0 ends up with top priority.
    always_comb begin
        busMux = '0;
        if (MDRout)   busMux = mdr_q;
        if (PCout)    busMux = pc_q;
        if (Zlowout)  busMux = z_q[31:0];
        if (Zhighout) busMux = z_q[63:32];
        if (LOout)    busMux = lo_q;
        if (HIout)    busMux = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (rOutVec[i]) busMux = r_q[i];
        end
    end

    assign opA     = y_q;
    assign opB     = busMux;
    assign shamt   = opB[4:0];
    assign product = $signed({{32{opA[31]}}, opA}) * $signed({{32{opB[31]}}, opB});

    always_comb begin
        quot = '0;
        rem  = '0;
        if (opB != 32'd0) begin
            quot = $signed(opA) / $signed(opB);
            rem  = $signed(opA) % $signed(opB);
        end
    end

    always_comb begin
        aluRes = '0;
        case (OpCode)
            5'd3, 5'd11: aluRes = {32'd0, opA + opB};
            5'd4:        aluRes = {32'd0, opA - opB};
            5'd5:        aluRes = {32'd0, opA >> shamt};
            5'd6:        aluRes = {32'd0, opA << shamt};
            // Shifting by 32 yields zero, so a zero rotate amount falls out naturally.
            5'd7:        aluRes = {32'd0, (opA >> shamt) | (opA << (6'd32 - {1'b0, shamt}))};
            5'd8:        aluRes = {32'd0, (opA << shamt) | (opA >> (6'd32 - {1'b0, shamt}))};
            5'd9:        aluRes = {32'd0, opA & opB};
            5'd10, 5'd13: aluRes = {32'd0, opA | opB};
            5'd12:       aluRes = {32'd0, opB + 32'd1};
            5'd14:       aluRes = product;
            5'd15:       aluRes = {rem, quot};
            5'd16:       aluRes = {32'd0, 32'd0 - opB};
            5'd17:       aluRes = {32'd0, ~opB};
            default:     aluRes = '0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            r_d[i] = rInVec[i] ? busMux : r_q[i];
        end
        hi_d  = HIin  ? busMux : hi_q;
        lo_d  = LOin  ? busMux : lo_q;
        pc_d  = PCin  ? busMux : pc_q;
        ir_d  = IRin  ? busMux : ir_q;
        mar_d = MARin ? busMux : mar_q;
        y_d   = Yin   ? busMux : y_q;
        mdr_d = MDRin ? (Read ? Mdatain : busMux) : mdr_q;
        z_d   = Zin   ? aluRes : z_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) begin
                r_q[i] <= '0;
            end
            hi_q  <= '0;
            lo_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                r_q[i] <= r_d[i];
            end
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            z_q   <= z_d;
        end
    end

    assign BusMuxOut  = busMux;
    assign IRout_val  = ir_q;
    assign MARout_val = mar_q;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: acts as the control unit, observes registers
// through the bus and compares against a queue of expected values.
module tb_datapath;

    localparam int SEL_HI    = 16;
    localparam int SEL_LO    = 17;
    localparam int SEL_ZHIGH = 18;
    localparam int SEL_ZLOW  = 19;
    localparam int SEL_PC    = 20;
    localparam int SEL_MDR   = 21;
    localparam int SEL_NONE  = 22;

    logic        clk;
    logic        clr;
    logic [15:0] rOut;
    logic [15:0] rIn;
    logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout;
    logic        HIin, LOin, PCin, IRin, MARin, MDRin, Yin, Zin, Read;
    logic [4:0]  OpCode;
    logic [31:0] Mdatain;
    wire  [31:0] BusMuxOut;
    wire  [31:0] IRout_val;
    wire  [31:0] MARout_val;

    logic [31:0] expQ [$];
    int          checkCount;
    int          errorCount;
    logic [4:0]  opTab  [8];
    logic [31:0] resTab [8];

    datapath dut (
        .clk(clk), .clr(clr),
        .R0out(rOut[0]),   .R1out(rOut[1]),   .R2out(rOut[2]),   .R3out(rOut[3]),
        .R4out(rOut[4]),   .R5out(rOut[5]),   .R6out(rOut[6]),   .R7out(rOut[7]),
        .R8out(rOut[8]),   .R9out(rOut[9]),   .R10out(rOut[10]), .R11out(rOut[11]),
        .R12out(rOut[12]), .R13out(rOut[13]), .R14out(rOut[14]), .R15out(rOut[15]),
        .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .MDRout(MDRout),
        .R0in(rIn[0]),   .R1in(rIn[1]),   .R2in(rIn[2]),   .R3in(rIn[3]),
        .R4in(rIn[4]),   .R5in(rIn[5]),   .R6in(rIn[6]),   .R7in(rIn[7]),
        .R8in(rIn[8]),   .R9in(rIn[9]),   .R10in(rIn[10]), .R11in(rIn[11]),
        .R12in(rIn[12]), .R13in(rIn[13]), .R14in(rIn[14]), .R15in(rIn[15]),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .MARin(MARin),
        .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .Read(Read),
        .OpCode(OpCode), .Mdatain(Mdatain),
        .BusMuxOut(BusMuxOut), .IRout_val(IRout_val), .MARout_val(MARout_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clearStrobes();
        rOut = '0; rIn = '0;
        HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MDRout = 0;
        HIin = 0; LOin = 0; PCin = 0; IRin = 0; MARin = 0; MDRin = 0;
        Yin = 0; Zin = 0; Read = 0; OpCode = '0;
    endtask

    // Strobes are set up beforehand; take one rising edge then release them.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        clearStrobes();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed);
        logic [31:0] expected;
        checkCount++;
        if (expQ.size() == 0) begin
            errorCount++;
            $error("[TB] FAIL %s: observed %h, scoreboard empty", tag, observed);
        end else begin
            expected = expQ.pop_front();
            assert (observed === expected) else begin
                errorCount++;
                $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            end
        end
    endtask

    task automatic peek(input string tag, input int sel);
        @(negedge clk);
        if (sel < 16) rOut[sel] = 1'b1;
        else begin
            case (sel)
                SEL_HI:    HIout    = 1'b1;
                SEL_LO:    LOout    = 1'b1;
                SEL_ZHIGH: Zhighout = 1'b1;
                SEL_ZLOW:  Zlowout  = 1'b1;
                SEL_PC:    PCout    = 1'b1;
                SEL_MDR:   MDRout   = 1'b1;
                default:   ;
            endcase
        end
        #1;
        checkOutput(tag, BusMuxOut);
        clearStrobes();
    endtask

    task automatic peekIr(input string tag);
        @(negedge clk);
        #1;
        checkOutput(tag, IRout_val);
    endtask

    task automatic peekMar(input string tag);
        @(negedge clk);
        #1;
        checkOutput(tag, MARout_val);
    endtask

    task automatic loadMdr(input logic [31:0] value);
        Mdatain = value; Read = 1; MDRin = 1;
        applyStimulus();
    endtask

    task automatic loadReg(input int idx, input logic [31:0] value);
        loadMdr(value);
        MDRout = 1; rIn[idx] = 1;
        applyStimulus();
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        clr = 1'b1;
        Mdatain = '0;
        clearStrobes();
        opTab  = '{5'd7, 5'd8, 5'd4, 5'd11, 5'd3, 5'd9, 5'd13, 5'd10};
        resTab = '{32'hA000_0001, 32'h68, 32'd10, 32'd16, 32'd16, 32'd1, 32'd15, 32'd15};
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;

        // Fill many registers, then pulse clr asynchronously mid-cycle.
        loadMdr(32'hDEAD_BEEF);
        MDRout = 1; rIn[2] = 1; HIin = 1; LOin = 1; PCin = 1; IRin = 1; MARin = 1;
        Yin = 1; Zin = 1; OpCode = 5'd12;
        applyStimulus();
        expQ.push_back(32'hDEAD_BEEF); peekIr("ir_preload");
        expQ.push_back(32'hDEAD_BEF0); peek("z_preload", SEL_ZLOW);
        #1;
        clr = 1'b1;
        repeat (9) expQ.push_back(32'd0);
        peekIr("rst_ir");
        peekMar("rst_mar");
        peek("rst_r2", 2);
        peek("rst_hi", SEL_HI);
        peek("rst_lo", SEL_LO);
        peek("rst_pc", SEL_PC);
        peek("rst_mdr", SEL_MDR);
        peek("rst_zlow", SEL_ZLOW);
        peek("rst_bus_idle", SEL_NONE);
        loadMdr(32'd5);
        @(negedge clk);
        clr = 1'b0;
        expQ.push_back(32'd0); peek("mdr_clr_override", SEL_MDR);
        loadMdr(32'd7);
        MDRout = 1; OpCode = 5'd3; Zin = 1;
        applyStimulus();
        expQ.push_back(32'd7); peek("y_cleared", SEL_ZLOW);

        // Register loads through MDR.
        loadReg(3, 32'd13);
        loadReg(5, 32'd3);
        loadReg(1, 32'd0);
        expQ.push_back(32'd13); peek("r3_load", 3);
        expQ.push_back(32'd3);  peek("r5_load", 5);
        expQ.push_back(32'd0);  peek("r1_load", 1);

        // Shift right 13 >> 3 into R1.
        rOut[3] = 1; Yin = 1; applyStimulus();
        rOut[5] = 1; OpCode = 5'd5; Zin = 1; applyStimulus();
        Zlowout = 1; rIn[1] = 1; applyStimulus();
        expQ.push_back(32'd1); peek("shr_r1", 1);
        expQ.push_back(32'd0); peek("shr_zhigh", SEL_ZHIGH);

        // Y = 13, bus = R5 = 3 across several ALU operations.
        for (int i = 0; i < 8; i++) begin
            rOut[5] = 1; OpCode = opTab[i]; Zin = 1;
            applyStimulus();
            expQ.push_back(resTab[i]);
            peek($sformatf("alu_op%0d", opTab[i]), SEL_ZLOW);
        end
        rOut[5] = 1; Yin = 1; applyStimulus();
        rOut[3] = 1; OpCode = 5'd6; Zin = 1; applyStimulus();
        expQ.push_back(32'h6000); peek("shl", SEL_ZLOW);

        // PC increment through Z.
        PCout = 1; MARin = 1; OpCode = 5'd12; Zin = 1; applyStimulus();
        expQ.push_back(32'd0); peekMar("mar_pc0");
        expQ.push_back(32'd1); peek("incpc_z", SEL_ZLOW);
        Zlowout = 1; PCin = 1; applyStimulus();
        expQ.push_back(32'd1); peek("pc_inc", SEL_PC);
        PCout = 1; MARin = 1; OpCode = 5'd12; Zin = 1; applyStimulus();
        expQ.push_back(32'd1); peekMar("mar_pc1");
        expQ.push_back(32'd2); peek("incpc_z2", SEL_ZLOW);

        // Instruction fetch.
        loadMdr(32'h2891_8000);
        MDRout = 1; IRin = 1; applyStimulus();
        expQ.push_back(32'h2891_8000); peekIr("ir_fetch");

        // Signed multiply / divide with Y = -6, bus = 4.
        loadMdr(32'hFFFF_FFFA);
        MDRout = 1; Yin = 1; applyStimulus();
        loadMdr(32'd4);
        MDRout = 1; OpCode = 5'd14; Zin = 1; applyStimulus();
        expQ.push_back(32'hFFFF_FFFF); peek("mul_hi", SEL_ZHIGH);
        expQ.push_back(32'hFFFF_FFE8); peek("mul_lo", SEL_ZLOW);
        MDRout = 1; OpCode = 5'd15; Zin = 1; applyStimulus();
        expQ.push_back(32'hFFFF_FFFE); peek("div_rem", SEL_ZHIGH);
        expQ.push_back(32'hFFFF_FFFF); peek("div_quot", SEL_ZLOW);
        OpCode = 5'd15; Zin = 1; applyStimulus();
        expQ.push_back(32'd0); peek("div0_hi", SEL_ZHIGH);
        expQ.push_back(32'd0); peek("div0_lo", SEL_ZLOW);
        MDRout = 1; OpCode = 5'd16; Zin = 1; applyStimulus();
        expQ.push_back(32'hFFFF_FFFC); peek("neg", SEL_ZLOW);
        MDRout = 1; OpCode = 5'd17; Zin = 1; applyStimulus();
        expQ.push_back(32'hFFFF_FFFB); peek("not", SEL_ZLOW);
        MDRout = 1; OpCode = 5'd31; Zin = 1; applyStimulus();
        expQ.push_back(32'd0); peek("invalid_op", SEL_ZLOW);

        // Bus priority with several sources asserted.
        @(negedge clk);
        rOut[3] = 1; rOut[5] = 1;
        #1;
        expQ.push_back(32'd13); checkOutput("prio_r3_r5", BusMuxOut);
        clearStrobes();
        @(negedge clk);
        PCout = 1; MDRout = 1;
        #1;
        expQ.push_back(32'd1); checkOutput("prio_pc_mdr", BusMuxOut);
        clearStrobes();

        // Self transfer and HI/LO loads.
        rOut[5] = 1; rIn[5] = 1; applyStimulus();
        expQ.push_back(32'd3); peek("self_r5", 5);
        MDRout = 1; HIin = 1; applyStimulus();
        rOut[3] = 1; LOin = 1; applyStimulus();
        expQ.push_back(32'd4);  peek("hi_load", SEL_HI);
        expQ.push_back(32'd13); peek("lo_load", SEL_LO);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
